max7219_ctrl: RTL and testbench
===============================

// Module: max7219_ctrl
// PURPOSE
//  Command sequencer for a MAX7219 8x8 LED driver behind the 16-bit spi_master.
//  - After reset: sends the MAX7219 init sequence, then refreshes all 8 digit registers from digit_data.
//  - Afterwards: performs a full refresh on each update request.
//  - Owns the spi_master start/data handshake and generates the LOAD (cs_n) strobe the master lacks.
// PARAMETERS
//  INTENSITY   4'h8  value written to intensity reg 0x0A (0x0..0xF)
//  SCAN_LIMIT  3'd7  value written to scan-limit reg 0x0B (digits 0..SCAN_LIMIT shown)
//  CS_HOLD     2     clk cycles cs_n held high between words (min 1)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous, active-low reset
//  enable      in   1   level; init sequence starts only while high
//  update      in   1   1-clk pulse: snapshot digit_data and refresh display
//  digit_data  in   64  row k (1..8) = digit_data[8k-1 -: 8]; row 1 = [7:0]
//  spi_busy    in   1   busy from spi_master
//  spi_start   out  1   1-clk start pulse to spi_master
//  spi_data    out  16  word to spi_master: {4'h0, addr[3:0], data[7:0]}
//  cs_n        out  1   MAX7219 LOAD; low during word, rising edge latches word
//  init_done   out  1   high once init sequence + first refresh completed
//  ready       out  1   high in IDLE_RDY with no pending update
// BEHAVIOUR
//  Reset:
//  - spi_start=0, spi_data=16'h0000, cs_n=1, init_done=0, ready=0.
//  - FSM=RST_WAIT; update_pending=0; snapshot=0.
//  - Reset mid-transfer aborts immediately; cs_n returns high asynchronously.
//  Word sub-sequence (every command):
//  - ISSUE: drive spi_data; spi_start=1 for exactly 1 clk; cs_n=0.
//  - WAIT_HI: wait spi_busy==1.
//  - WAIT_LO: wait spi_busy==0; then cs_n=1 at the next edge.
//  - GAP: cs_n high CS_HOLD clks; then advance to the next word.
//  - spi_data is stable from ISSUE until WAIT_LO exits.
//  - spi_start is never asserted while spi_busy=1 or while cs_n=1.
//  Sequence:
//  - RST_WAIT -> INIT when enable=1.
//  - INIT sends, in order: 0x0F00 (test off), 0x0900 (no decode), {0x0B,5'b0,SCAN_LIMIT}, {0x0A,4'h0,INTENSITY}, 0x0C01 (normal op).
//  - Then REFRESH: snapshot digit_data at entry; send 0x01xx..0x08xx, digit 1 first.
//  - Then IDLE_RDY.
//  - init_done rises on the cycle IDLE_RDY is first entered and stays high until reset.
//  - IDLE_RDY -> REFRESH on update (or pending); pending is cleared at REFRESH entry.
//  Boundary conditions:
//  - update while not IDLE_RDY (incl. INIT): sets update_pending; multiple pulses coalesce into one.
//  - Snapshot is taken only at REFRESH entry; digit_data changes mid-refresh are ignored.
//  - update and REFRESH completion in the same clk: one further refresh follows.
//  - enable low after INIT started: ignored; sequence completes.
//  - Word counter 0..7 must not wrap into address 0x00 or 0x09.
// TESTING
//  1. Reset, enable=1, spi model replies busy 64 clk per word -> 13 words: 0F00,0900,0B07,0A08,0C01,0100..0800; init_done=1 after 13th cs_n rise.
//  2. digit_data=64'h8040201008040201, update pulse -> words 0101,0202,0304,0408,0510,0620,0740,0880; ready low during, high after.
//  3. 3 update pulses during word 2 of a refresh -> exactly one extra 8-word refresh; no lost or duplicated words.
//  4. enable=0 after reset -> spi_start never pulses for 1000 clk, cs_n=1; raise enable -> sequence of test 1.
//  5. rst_n low during word 3 of INIT -> cs_n=1, spi_start=0 immediately; after release + enable, restart from 0F00.
//  6. Every word: cs_n low 1 clk before/with spi_start, stays low until busy falls; high >= CS_HOLD clk between words.

Source files
------------

// File: rtl/max7219_ctrl.sv
// max7219_ctrl: sequences the MAX7219 init words and 8-digit refreshes over a 16-bit SPI master.
// Latency: a word starts 1 clk after its ISSUE state is entered, and each word then waits for spi_busy to rise and fall.
// Backpressure: spi_start is held off while spi_busy is high; update pulses seen outside IDLE_RDY coalesce into one pending refresh.
//
// Ports: clk/rst_n (async active-low), enable (init gate), update (refresh request),
//        digit_data (8 rows, row 1 in [7:0]), spi_busy / spi_start / spi_data (master handshake),
//        cs_n (MAX7219 LOAD), init_done (sticky after first full refresh), ready (idle, nothing pending).
module max7219_ctrl #(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7,
    parameter int         CS_HOLD    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        update,
    input  logic [63:0] digit_data,
    input  logic        spi_busy,
    output logic        spi_start,
    output logic [15:0] spi_data,
    output logic        cs_n,
    output logic        init_done,
    output logic        ready
);

    localparam int GAP_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    typedef enum logic [2:0] {
        S_RST_WAIT,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic               refresh_q, refresh_d;   // 0: init words, 1: digit words
    logic [2:0]         idx_q, idx_d;           // word index within the current phase
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               pend_q, pend_d;
    logic [63:0]        snap_q, snap_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               begin_ref;

    // Word for a given phase/index. Digit addresses are idx+1, so a 3-bit
    // index can only ever produce addresses 0x1..0x8.
    function automatic logic [15:0] word_f(input logic refresh, input logic [2:0] idx,
                                           input logic [63:0] snap);
        logic [15:0] w;
        if (refresh) begin
            w = {4'h0, ({1'b0, idx} + 4'd1), snap[{idx, 3'b000} +: 8]};
        end else begin
            case (idx)
                3'd0:    w = 16'h0F00;
                3'd1:    w = 16'h0900;
                3'd2:    w = {8'h0B, 5'b0, SCAN_LIMIT};
                3'd3:    w = {8'h0A, 4'h0, INTENSITY};
                default: w = 16'h0C01;
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST_WAIT;
            refresh_q <= 1'b0;
            idx_q     <= 3'd0;
            gap_q     <= '0;
            pend_q    <= 1'b0;
            snap_q    <= 64'd0;
            data_q    <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
            snap_q    <= snap_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pend_d    = pend_q;
        snap_d    = snap_q;
        data_d    = data_q;
        done_d    = done_q;
        begin_ref = 1'b0;

        case (state_q)
            S_RST_WAIT: begin
                if (enable) begin
                    state_d   = S_ISSUE;
                    refresh_d = 1'b0;
                    idx_d     = 3'd0;
                    data_d    = word_f(1'b0, 3'd0, snap_q);
                end
            end
            S_ISSUE: begin
                if (!spi_busy) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (spi_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!spi_busy) begin
                    state_d = S_GAP;
                    gap_d   = GAP_W'(CS_HOLD - 1);
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (!refresh_q && idx_q == 3'd4) begin
                    begin_ref = 1'b1;
                end else if (refresh_q && idx_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    idx_d   = idx_q + 3'd1;
                    data_d  = word_f(refresh_q, idx_q + 3'd1, snap_q);
                end
            end
            S_IDLE: begin
                if (update || pend_q) begin_ref = 1'b1;
            end
            default: state_d = S_RST_WAIT;
        endcase

        // Refresh entry: snapshot rows so later digit_data changes are ignored.
        if (begin_ref) begin
            state_d   = S_ISSUE;
            refresh_d = 1'b1;
            idx_d     = 3'd0;
            snap_d    = digit_data;
            data_d    = word_f(1'b1, 3'd0, digit_data);
            pend_d    = 1'b0;
        end

        // Applied after the entry clear so a request landing on the entry
        // cycle of a refresh is never lost.
        if (update && state_q != S_IDLE) pend_d = 1'b1;
    end

    assign spi_start = (state_q == S_ISSUE) && !spi_busy;
    assign cs_n      = !((state_q == S_ISSUE) || (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO));
    assign spi_data  = data_q;
    assign init_done = done_q;
    assign ready     = (state_q == S_IDLE) && !pend_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// tb_max7219_ctrl: randomized scoreboard bench for max7219_ctrl with a behavioural SPI slave.
// Latency: not applicable (bench).
// Backpressure: the SPI model holds spi_busy high for busy_len clks per word.
module tb_max7219_ctrl;

    localparam int CS_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        update;
    logic [63:0] digit_data;
    logic        spi_busy;
    logic        spi_start;
    logic [15:0] spi_data;
    logic        cs_n;
    logic        init_done;
    logic        ready;

    always #5 clk = ~clk;

    max7219_ctrl #(
        .INTENSITY (4'h8),
        .SCAN_LIMIT(3'd7),
        .CS_HOLD   (CS_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .update    (update),
        .digit_data(digit_data),
        .spi_busy  (spi_busy),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .cs_n      (cs_n),
        .init_done (init_done),
        .ready     (ready)
    );

    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int cs_low_samples = 0;
    int busy_len = 64;
    logic mon_prev_cs = 1'b1;
    int mon_hi_cnt = CS_HOLD;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the words the display must receive, in order.
    task automatic push_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0C01);
    endtask

    task automatic push_refresh(input logic [63:0] dd);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back({4'h0, 4'(k), dd[8*k-1 -: 8]});
        end
    endtask

    // SPI master model: busy rises the clk after start and lasts busy_len clks.
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spi_busy = 1'b0;
            end else if (spi_start === 1'b1) begin
                start_cnt++;
                check("start_with_cs_low", cs_n, 1'b0);
                @(negedge clk);
                spi_busy = rst_n;
                for (int i = 0; i < busy_len && rst_n; i++) @(negedge clk);
                spi_busy = 1'b0;
            end
        end
    end

    // Monitor: each cs_n rise latches one word; compare against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_cs = 1'b1;
                mon_hi_cnt  = CS_HOLD;
            end else begin
                if (cs_n === 1'b0) cs_low_samples++;
                if (mon_prev_cs === 1'b0 && cs_n === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %04h, expected no word", spi_data);
                    end else begin
                        check("word", spi_data, exp_q.pop_front());
                    end
                end
                if (mon_prev_cs === 1'b1 && cs_n === 1'b0) begin
                    n_vec++;
                    if (mon_hi_cnt < CS_HOLD) begin
                        n_err++;
                        $display("FAIL cs_hold: got %0d clks high, expected >= %0d", mon_hi_cnt, CS_HOLD);
                    end
                    mon_hi_cnt = 0;
                end
                if (cs_n === 1'b1) mon_hi_cnt++;
                mon_prev_cs = cs_n;
            end
        end
    end

    task automatic wait_starts(input int target, input int budget);
        int i = 0;
        while (start_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (start_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_starts: got %0d starts, expected %0d", start_cnt, target);
        end
    endtask

    task automatic wait_ready(input int budget);
        int i = 0;
        while (ready !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ready: got ready=%b, expected 1 within %0d clks", ready, budget);
        end
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int low_base;
        logic [63:0] dd;
        logic [63:0] d2;
        int npulse;
        logic coalesce;

        rst_n      = 1'b0;
        enable     = 1'b0;
        update     = 1'b0;
        digit_data = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_spi_data",  spi_data,  16'h0000);
        check("rst_cs_n",      cs_n,      1'b1);
        check("rst_init_done", init_done, 1'b0);
        check("rst_ready",     ready,     1'b0);
        rst_n = 1'b1;

        // enable low: nothing happens
        low_base = cs_low_samples;
        repeat (1000) @(negedge clk);
        check("noenable_starts", start_cnt, 0);
        check("noenable_cs_low", cs_low_samples - low_base, 0);
        check("noenable_ready",  ready, 1'b0);

        // init + first refresh, 64-clk busy per word; enable dropped mid-init
        digit_data = {$urandom, $urandom};
        push_init();
        push_refresh(digit_data);
        enable = 1'b1;
        wait_starts(1, 100);
        enable = 1'b0;
        wait_starts(2, 200);
        check("init_done_early", init_done, 1'b0);
        wait_ready(5000);
        check("init_done_after", init_done, 1'b1);
        check("init_words_left", exp_q.size(), 0);

        // refreshes, some with coalesced mid-refresh update bursts
        for (int it = 0; it < 8; it++) begin
            busy_len = $urandom_range(3, 10);
            base = start_cnt;
            dd = (it == 0) ? 64'h8040201008040201 : {$urandom, $urandom};
            digit_data = dd;
            push_refresh(dd);
            pulse_update();
            wait_starts(base + 1, 200);
            check("ready_low_busy", ready, 1'b0);
            digit_data = {$urandom, $urandom};
            coalesce = (it == 1) || ($urandom_range(0, 1) == 1);
            if (coalesce) begin
                wait_starts(base + 2, 200);
                d2 = {$urandom, $urandom};
                digit_data = d2;
                push_refresh(d2);
                npulse = (it == 1) ? 3 : $urandom_range(1, 3);
                for (int p = 0; p < npulse; p++) begin
                    pulse_update();
                    @(negedge clk);
                end
                wait_starts(base + 9, 400);
                digit_data = {$urandom, $urandom};
            end
            wait_ready(1000);
            check("ready_after", ready, 1'b1);
            check("refresh_words_left", exp_q.size(), 0);
        end

        // reset during word 3 of init, then restart from the first init word
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n    = 1'b1;
        busy_len = 8;
        push_init();
        push_refresh(digit_data);
        base   = start_cnt;
        enable = 1'b1;
        wait_starts(base + 3, 400);
        repeat (3) @(negedge clk);
        check("mid_word_cs_low", cs_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cs_n",      cs_n,      1'b1);
        check("abort_spi_start", spi_start, 1'b0);
        check("abort_init_done", init_done, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_refresh(digit_data);
        rst_n = 1'b1;
        wait_ready(3000);
        check("restart_init_done",  init_done, 1'b1);
        check("restart_words_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
